// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - length-prefixed UART byte stream loader into sequential memory words
module uart_mem_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byteValid,
  input  logic [7:0]            byteIn,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           wordCount
);

  localparam int          BYTES = DATA_WIDTH / 8;
  localparam logic [32:0] LIMIT = 33'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;

  state_t                r_state, w_state_n;
  logic [15:0]           r_len, w_len_n;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_n;
  logic [1:0]            r_bidx, w_bidx_n;
  logic [15:0]           r_wcnt, w_wcnt_n;
  logic                  r_wr, w_wr_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [DATA_WIDTH-1:0] r_data, w_data_n;
  logic                  r_busy, r_done, r_error;

  logic [15:0]           w_len_full;
  logic [32:0]           w_need;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_len_full = {r_len[15:8], byteIn};
  assign w_need     = 33'(BASE_ADDR) + {17'd0, w_len_full};
  // Shifting left by a byte drops the oldest byte, so only the last BYTES bytes survive.
  assign w_word     = (r_shift << 8) | DATA_WIDTH'(byteIn);

  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_shift_n = r_shift;
    w_bidx_n  = r_bidx;
    w_wcnt_n  = r_wcnt;
    w_wr_n    = 1'b0;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    if (start) begin
      w_state_n = S_LEN_HI;
      w_shift_n = '0;
      w_bidx_n  = 2'd0;
      w_wcnt_n  = 16'd0;
    end else if (byteValid) begin
      unique case (r_state)
        S_LEN_HI: begin
          w_len_n   = {byteIn, r_len[7:0]};
          w_state_n = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_len_n = w_len_full;
          if (w_len_full == 16'd0) begin
            w_state_n = S_DONE;
          end else if (w_need > LIMIT) begin
            w_state_n = S_ERR;
          end else begin
            w_state_n = S_DATA;
            w_bidx_n  = 2'd0;
            w_wcnt_n  = 16'd0;
            w_shift_n = '0;
          end
        end
        S_DATA: begin
          w_shift_n = w_word;
          if (r_bidx == 2'(BYTES - 1)) begin
            w_wr_n   = 1'b1;
            w_data_n = w_word;
            w_addr_n = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_wcnt);
            w_wcnt_n = r_wcnt + 16'd1;
            w_bidx_n = 2'd0;
            if (r_wcnt + 16'd1 == r_len) w_state_n = S_DONE;
          end else begin
            w_bidx_n = r_bidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
      r_shift <= '0;
      r_bidx  <= 2'd0;
      r_wcnt  <= 16'd0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_len   <= w_len_n;
      r_shift <= w_shift_n;
      r_bidx  <= w_bidx_n;
      r_wcnt  <= w_wcnt_n;
      r_wr    <= w_wr_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_busy  <= (w_state_n == S_LEN_HI) || (w_state_n == S_LEN_LO) || (w_state_n == S_DATA);
      r_done  <= (w_state_n == S_DONE);
      r_error <= (w_state_n == S_ERR);
    end
  end

  assign memWrEn   = r_wr;
  assign memAddr   = r_addr;
  assign memData   = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign wordCount = r_wcnt;

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - randomized self-checking bench for uart_mem_loader
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0, bv1 = 1'b0;
  logic [7:0]  bi1 = 8'h00;
  logic        wr1, busy1, done1, err1;
  logic [11:0] addr1;
  logic [15:0] data1, wc1;
  logic        start2 = 1'b0, bv2 = 1'b0;
  logic [7:0]  bi2 = 8'h00;
  logic        wr2, busy2, done2, err2;
  logic [3:0]  addr2;
  logic [31:0] data2;
  logic [15:0] wc2;

  int n_chk = 0;
  int n_fail = 0;

  logic [27:0] q1[$];
  logic [27:0] e1[$];
  logic [35:0] q2[$];
  logic [35:0] e2[$];

  uart_mem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start1), .byteValid(bv1), .byteIn(bi1),
    .memWrEn(wr1), .memAddr(addr1), .memData(data1), .busy(busy1),
    .done(done1), .error(err1), .wordCount(wc1));

  uart_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .byteValid(bv2), .byteIn(bi2),
    .memWrEn(wr2), .memAddr(addr2), .memData(data2), .busy(busy2),
    .done(done2), .error(err2), .wordCount(wc2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr1) q1.push_back({addr1, data1});
    if (wr2) q2.push_back({addr2, data2});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] b);
    bv1 = 1'b1; bi1 = b; tick(); bv1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    bv2 = 1'b1; bi2 = b; tick(); bv2 = 1'b0;
  endtask

  task automatic start_1();
    start1 = 1'b1; tick(); start1 = 1'b0;
  endtask

  task automatic start_2();
    start2 = 1'b1; tick(); start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_chk++; if ({wr1, addr1, data1} !== 29'd0) begin n_fail++; $display("FAIL reset_mem got %0h want 0", {wr1, addr1, data1}); end
    n_chk++; if ({busy1, done1, err1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy1, done1, err1}); end
    n_chk++; if (wc1 !== 16'd0) begin n_fail++; $display("FAIL reset_wc got %0d want 0", wc1); end
    n_chk++; if ({wr2, busy2, done2, err2, addr2, data2, wc2} !== 56'd0) begin n_fail++; $display("FAIL reset_dut2 got %0h want 0", {wr2, busy2, done2, err2}); end
    rst = 1'b1;
    tick();
    send1(8'h00); send1(8'h01); send1(8'h12); send1(8'h34);
    tick();
    n_chk++; if ({q1.size(), busy1} !== 33'd0) begin n_fail++; $display("FAIL idle_ignores_bytes got writes=%0d busy=%0b want 0 0", q1.size(), busy1); end
  endtask

  task automatic test_basic_frame();
    q1.delete();
    start_1();
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_start got %0b want 1", busy1); end
    send1(8'h00); send1(8'h02); send1(8'h12); send1(8'h34);
    n_chk++; if ({wr1, addr1, data1, done1} !== {1'b1, 12'd0, 16'h1234, 1'b0}) begin n_fail++; $display("FAIL basic_w0 got wr=%0b a=%0h d=%0h done=%0b want 1 0 1234 0", wr1, addr1, data1, done1); end
    send1(8'hAB); send1(8'hCD);
    n_chk++; if ({wr1, addr1, data1, done1, busy1, wc1} !== {1'b1, 12'd1, 16'hABCD, 1'b1, 1'b0, 16'd2}) begin n_fail++; $display("FAIL basic_w1 got wr=%0b a=%0h d=%0h done=%0b busy=%0b wc=%0d want 1 1 abcd 1 0 2", wr1, addr1, data1, done1, busy1, wc1); end
    tick();
    n_chk++; if ({wr1, addr1, data1, done1} !== {1'b0, 12'd1, 16'hABCD, 1'b1}) begin n_fail++; $display("FAIL basic_hold got wr=%0b a=%0h d=%0h done=%0b want 0 1 abcd 1", wr1, addr1, data1, done1); end
    send1(8'h77); send1(8'h88); tick();
    n_chk++; if ({q1.size(), done1} !== {32'd2, 1'b1}) begin n_fail++; $display("FAIL basic_done_ignores got writes=%0d done=%0b want 2 1", q1.size(), done1); end
  endtask

  task automatic test_zero_len();
    q1.delete();
    start_1();
    send1(8'h00); send1(8'h00);
    n_chk++; if ({done1, busy1, err1, wr1} !== 4'b1000) begin n_fail++; $display("FAIL zero_len got done/busy/err/wr=%b want 1000", {done1, busy1, err1, wr1}); end
    tick();
    n_chk++; if (q1.size() != 0) begin n_fail++; $display("FAIL zero_len_writes got %0d want 0", q1.size()); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int n;
      logic [15:0] w;
      n = $urandom_range(1, 12);
      q1.delete(); e1.delete();
      start_1();
      send1(8'(n >> 8)); send1(8'(n));
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        e1.push_back({12'(i), w});
        send1(w[15:8]);
        if (f[0]) repeat ($urandom_range(0, 2)) tick();
        send1(w[7:0]);
        n_chk++; if ({wr1, addr1, data1, wc1, done1} !== {1'b1, 12'(i), w, 16'(i + 1), (i == n - 1)}) begin n_fail++; $display("FAIL rand_word f=%0d i=%0d got wr=%0b a=%0h d=%0h wc=%0d done=%0b want a=%0h d=%0h", f, i, wr1, addr1, data1, wc1, done1, i, w); end
        if (f[0]) repeat ($urandom_range(0, 2)) tick();
      end
      tick(); tick();
      n_chk++;
      if (q1.size() != e1.size()) begin n_fail++; $display("FAIL rand_count f=%0d got %0d want %0d", f, q1.size(), e1.size()); end
      else for (int i = 0; i < e1.size(); i++) begin
        n_chk++; if (q1[i] !== e1[i]) begin n_fail++; $display("FAIL rand_write f=%0d i=%0d got %0h want %0h", f, i, q1[i], e1[i]); end
      end
    end
  endtask

  task automatic test_range_error();
    q1.delete();
    start_1();
    send1(8'h10); send1(8'h01);
    n_chk++; if ({err1, busy1, done1} !== 3'b100) begin n_fail++; $display("FAIL err_4097 got err/busy/done=%b want 100", {err1, busy1, done1}); end
    send1(8'h00); send1(8'h11); send1(8'h22); tick();
    n_chk++; if ({q1.size(), err1} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL err_ignores got writes=%0d err=%0b want 0 1", q1.size(), err1); end
    start_1();
    n_chk++; if ({err1, busy1} !== 2'b01) begin n_fail++; $display("FAIL err_cleared got err/busy=%b want 01", {err1, busy1}); end
    send1(8'h10); send1(8'h00);
    n_chk++; if ({err1, busy1, done1} !== 3'b010) begin n_fail++; $display("FAIL len_4096_ok got err/busy/done=%b want 010", {err1, busy1, done1}); end
    start_1();
    send1(8'h00); send1(8'h00);
  endtask

  task automatic test_abort();
    q1.delete();
    start_1();
    send1(8'h00); send1(8'h03); send1(8'h11); send1(8'h22); send1(8'h33);
    start_1();
    n_chk++; if ({wc1, busy1} !== {16'd0, 1'b1}) begin n_fail++; $display("FAIL abort_clear got wc=%0d busy=%0b want 0 1", wc1, busy1); end
    send1(8'h00); send1(8'h01); send1(8'h55); send1(8'h66);
    tick(); tick();
    n_chk++; if (q1.size() != 2) begin n_fail++; $display("FAIL abort_count got %0d want 2", q1.size()); end
    else begin
      n_chk++; if (q1[0] !== {12'd0, 16'h1122}) begin n_fail++; $display("FAIL abort_first got %0h want 0001122", q1[0]); end
      n_chk++; if (q1[1] !== {12'd0, 16'h5566}) begin n_fail++; $display("FAIL abort_second got %0h want 0005566", q1[1]); end
    end
    q1.delete();
    start_1();
    send1(8'h00); send1(8'h02); send1(8'h11);
    start_1();
    send1(8'h00); send1(8'h01); send1(8'h55); send1(8'h66);
    tick(); tick();
    n_chk++; if (q1.size() != 1 || q1[0] !== {12'd0, 16'h5566}) begin n_fail++; $display("FAIL abort_partial got n=%0d first=%0h want 1 0005566", q1.size(), q1.size() > 0 ? q1[0] : 28'd0); end
  endtask

  task automatic test_start_with_byte();
    q1.delete();
    start1 = 1'b1; bv1 = 1'b1; bi1 = 8'h07; tick(); start1 = 1'b0; bv1 = 1'b0;
    send1(8'h00); send1(8'h01); send1(8'hAA); send1(8'hBB);
    n_chk++; if ({wr1, addr1, data1, done1} !== {1'b1, 12'd0, 16'hAABB, 1'b1}) begin n_fail++; $display("FAIL start_byte_drop got wr=%0b a=%0h d=%0h done=%0b want 1 0 aabb 1", wr1, addr1, data1, done1); end
  endtask

  task automatic test_wide();
    logic [31:0] w;
    q2.delete(); e2.delete();
    start_2();
    send2(8'h00); send2(8'h01); send2(8'hDE); send2(8'hAD); send2(8'hBE);
    n_chk++; if (wr2 !== 1'b0) begin n_fail++; $display("FAIL wide_early got wr=%0b want 0", wr2); end
    send2(8'hEF);
    n_chk++; if ({wr2, addr2, data2, done2} !== {1'b1, 4'd8, 32'hDEADBEEF, 1'b1}) begin n_fail++; $display("FAIL wide_word got wr=%0b a=%0h d=%0h done=%0b want 1 8 deadbeef 1", wr2, addr2, data2, done2); end
    start_2();
    send2(8'h00); send2(8'h09);
    n_chk++; if ({err2, busy2} !== 2'b10) begin n_fail++; $display("FAIL wide_err9 got err/busy=%b want 10", {err2, busy2}); end
    q2.delete();
    start_2();
    send2(8'h00); send2(8'h08);
    n_chk++; if ({err2, busy2} !== 2'b01) begin n_fail++; $display("FAIL wide_len8 got err/busy=%b want 01", {err2, busy2}); end
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      e2.push_back({4'(8 + i), w});
      for (int b = 3; b >= 0; b--) send2(w[b*8 +: 8]);
    end
    tick(); tick();
    n_chk++; if ({done2, wc2} !== {1'b1, 16'd8}) begin n_fail++; $display("FAIL wide_done got done=%0b wc=%0d want 1 8", done2, wc2); end
    n_chk++;
    if (q2.size() != e2.size()) begin n_fail++; $display("FAIL wide_count got %0d want %0d", q2.size(), e2.size()); end
    else for (int i = 0; i < e2.size(); i++) begin
      n_chk++; if (q2[i] !== e2[i]) begin n_fail++; $display("FAIL wide_write i=%0d got %0h want %0h", i, q2[i], e2[i]); end
    end
  endtask

  task automatic test_reset_mid();
    q1.delete();
    start_1();
    send1(8'h00); send1(8'h02); send1(8'h12);
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({wr1, addr1, data1, busy1, done1, err1, wc1} !== 47'd0) begin n_fail++; $display("FAIL reset_mid got wr=%0b a=%0h d=%0h busy=%0b wc=%0d want all 0", wr1, addr1, data1, busy1, wc1); end
    tick();
    rst = 1'b1;
    tick();
    send1(8'h34); send1(8'h00); send1(8'h01); send1(8'h56); send1(8'h78);
    tick();
    n_chk++; if ({q1.size(), busy1, done1} !== 34'd0) begin n_fail++; $display("FAIL reset_no_start got writes=%0d busy=%0b done=%0b want 0 0 0", q1.size(), busy1, done1); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_zero_len();
    test_random_frames();
    test_range_error();
    test_abort();
    test_start_with_byte();
    test_wide();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
